// File: rtl/counter_bcd_mod_pkg.sv
// Shared definitions for the BCD modulo counter family: digit width,
// clock-unit moduli, operation encoding and BCD helper functions.
package counter_bcd_mod_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 4;
    localparam int EXT_W      = BCD_W * MAX_DIGITS;

    localparam int SEC_MOD    = 60;
    localparam int HOUR24_MOD = 24;
    localparam int HOUR12_MIN = 1;
    localparam int HOUR12_MOD = 12;

    // What the digit chain does on the next edge
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_INC  = 3'd2,
        OP_DEC  = 3'd3,
        OP_WRAP = 3'd4
    } cnt_op_e;

    // Decimal integer to packed BCD, digit 0 in the low nibble
    function automatic logic [EXT_W-1:0] to_bcd(input int value);
        logic [EXT_W-1:0] res;
        int               rem;
        res = {EXT_W{1'b0}};
        rem = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            res[i*BCD_W +: BCD_W] = BCD_W'(rem % 10);
            rem = rem / 10;
        end
        return res;
    endfunction

    // True when every nibble holds a decimal digit 0..9
    function automatic logic bcd_valid(input logic [EXT_W-1:0] vec);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (vec[i*BCD_W +: BCD_W] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // lo <= v <= hi on valid BCD; packed BCD order equals numeric order,
    // so a borrow from each subtraction flags an out-of-range value
    function automatic logic bcd_in_range(input logic [EXT_W-1:0] v,
                                          input logic [EXT_W-1:0] lo,
                                          input logic [EXT_W-1:0] hi);
        logic [EXT_W:0] d_lo;
        logic [EXT_W:0] d_hi;
        d_lo = {1'b0, v}  - {1'b0, lo};
        d_hi = {1'b0, hi} - {1'b0, v};
        return ~d_lo[EXT_W] & ~d_hi[EXT_W];
    endfunction

endpackage

// File: rtl/counter_bcd_mod_if.sv
// Count/preset bus of one counter stage. The driver of cin/dir/PE/pre_val
// uses the master view; the counter itself uses the slave view.
interface counter_bcd_mod_if #(parameter int W = 8);

    logic         cin;
    logic         dir;
    logic         PE;
    logic [W-1:0] pre_val;
    logic         cout;
    logic [W-1:0] show;
    logic         load_err;

    modport master (
        output cin, dir, PE, pre_val,
        input  cout, show, load_err
    );

    modport slave (
        input  cin, dir, PE, pre_val,
        output cout, show, load_err
    );

endinterface

// File: rtl/counter_bcd_mod_bcd_digit.sv
// One decade of the counter: a 4-bit BCD register that can be loaded,
// forced to a wrap value, incremented or decremented, and reports 9/0.
module bcd_digit
    import counter_bcd_mod_pkg::*;
#(
    parameter logic [BCD_W-1:0] RST_VAL = 4'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             force_en,
    input  logic [BCD_W-1:0] force_val,
    input  logic             inc,
    input  logic             dec,
    output logic [BCD_W-1:0] q,
    output logic             at9,
    output logic             at0
);

    logic [BCD_W-1:0] q_r;
    logic [BCD_W-1:0] q_next_s;

    // Next digit value; load wins over force, force over stepping
    always_comb begin
        q_next_s = q_r;
        if (load) begin
            q_next_s = load_val;
        end else if (force_en) begin
            q_next_s = force_val;
        end else if (inc) begin
            q_next_s = (q_r == 4'd9) ? 4'd0 : q_r + 4'd1;
        end else if (dec) begin
            q_next_s = (q_r == 4'd0) ? 4'd9 : q_r - 4'd1;
        end else begin
            q_next_s = q_r;
        end
    end

    // Digit register, cleared to this decade's share of the minimum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= q_next_s;
        end
    end

    assign q   = q_r;
    assign at9 = (q_r == 4'd9);
    assign at0 = (q_r == 4'd0);

endmodule

// File: rtl/counter_bcd_mod.sv
// Parametrised BCD modulo counter (seconds/minutes/hours building block).
// Counts up or down over MIN_VAL..MIN_VAL+MODULUS-1, accepts range-checked
// presets and emits a same-cycle carry/borrow for cascading stages.
module counter_bcd_mod
    import counter_bcd_mod_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60,
    parameter int MIN_VAL = 0
) (
    input  logic               clk,
    input  logic               _CR,
    counter_bcd_mod_if.slave   bus
);

    localparam int W       = BCD_W * DIGITS;
    localparam int MAX_VAL = MIN_VAL + MODULUS - 1;

    localparam logic [EXT_W-1:0] MIN_BCD16 = to_bcd(MIN_VAL);
    localparam logic [EXT_W-1:0] MAX_BCD16 = to_bcd(MAX_VAL);
    localparam logic [W-1:0]     MIN_BCD   = MIN_BCD16[W-1:0];
    localparam logic [W-1:0]     MAX_BCD   = MAX_BCD16[W-1:0];

    generate
        if (MODULUS < 2) begin : g_chk_modulus
            $error("counter_bcd_mod: MODULUS must be at least 2");
        end
        if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_chk_digits
            $error("counter_bcd_mod: DIGITS must be in 1..4");
        end
        if (MIN_VAL < 0 || MAX_VAL > (10 ** DIGITS) - 1) begin : g_chk_range
            $error("counter_bcd_mod: value range does not fit in DIGITS decades");
        end
    endgenerate

    logic [W-1:0]      show_s;
    logic [EXT_W-1:0]  show_ext_s;
    logic [EXT_W-1:0]  pre_ext_s;
    logic              pre_ok_s;
    logic              state_ok_s;
    logic              at_min_s;
    logic              at_max_s;
    logic [DIGITS-1:0] at9_s;
    logic [DIGITS-1:0] at0_s;
    logic [DIGITS:0]   nines_s;
    logic [DIGITS:0]   zeros_s;
    cnt_op_e           op_s;
    logic [W-1:0]      wrap_val_s;
    logic              load_en_s;
    logic              wrap_en_s;
    logic              inc_en_s;
    logic              dec_en_s;
    logic              load_err_r;

    assign show_ext_s = EXT_W'(show_s);
    assign pre_ext_s  = EXT_W'(bus.pre_val);

    // A preset is only taken when it is proper BCD and inside the range;
    // the same test on the live value catches upset (corrupted) states
    assign pre_ok_s   = bcd_valid(pre_ext_s)  & bcd_in_range(pre_ext_s,  MIN_BCD16, MAX_BCD16);
    assign state_ok_s = bcd_valid(show_ext_s) & bcd_in_range(show_ext_s, MIN_BCD16, MAX_BCD16);

    assign at_min_s = (show_s == MIN_BCD);
    assign at_max_s = (show_s == MAX_BCD);

    // Ripple qualifiers: digit i steps when all lower digits are at 9 (up) / 0 (down)
    assign nines_s[0] = 1'b1;
    assign zeros_s[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit #(
                .RST_VAL(MIN_BCD16[gi*BCD_W +: BCD_W])
            ) u_digit (
                .clk       (clk),
                .rst_n     (_CR),
                .load      (load_en_s),
                .load_val  (bus.pre_val[gi*BCD_W +: BCD_W]),
                .force_en  (wrap_en_s),
                .force_val (wrap_val_s[gi*BCD_W +: BCD_W]),
                .inc       (inc_en_s & nines_s[gi]),
                .dec       (dec_en_s & zeros_s[gi]),
                .q         (show_s[gi*BCD_W +: BCD_W]),
                .at9       (at9_s[gi]),
                .at0       (at0_s[gi])
            );
            assign nines_s[gi+1] = nines_s[gi] & at9_s[gi];
            assign zeros_s[gi+1] = zeros_s[gi] & at0_s[gi];
        end
    endgenerate

    // Choose the edge operation: preset beats counting; counting from a
    // corrupted value recovers to the minimum. A full 9..9 or 0..0 ripple
    // can only happen at (or beyond) a terminal value, so it wraps too.
    always_comb begin
        op_s       = OP_HOLD;
        wrap_val_s = MIN_BCD;
        if (bus.PE) begin
            if (pre_ok_s) begin
                op_s = OP_LOAD;
            end else begin
                op_s = OP_HOLD;
            end
        end else if (bus.cin) begin
            if (!state_ok_s) begin
                op_s       = OP_WRAP;
                wrap_val_s = MIN_BCD;
            end else if (bus.dir) begin
                if (at_min_s || zeros_s[DIGITS]) begin
                    op_s       = OP_WRAP;
                    wrap_val_s = MAX_BCD;
                end else begin
                    op_s = OP_DEC;
                end
            end else begin
                if (at_max_s || nines_s[DIGITS]) begin
                    op_s       = OP_WRAP;
                    wrap_val_s = MIN_BCD;
                end else begin
                    op_s = OP_INC;
                end
            end
        end else begin
            op_s = OP_HOLD;
        end
    end

    // Decode the chosen operation into the digit strobes
    always_comb begin
        load_en_s = 1'b0;
        wrap_en_s = 1'b0;
        inc_en_s  = 1'b0;
        dec_en_s  = 1'b0;
        case (op_s)
            OP_LOAD: load_en_s = 1'b1;
            OP_WRAP: wrap_en_s = 1'b1;
            OP_INC:  inc_en_s  = 1'b1;
            OP_DEC:  dec_en_s  = 1'b1;
            OP_HOLD: load_en_s = 1'b0;
            default: load_en_s = 1'b0;
        endcase
    end

    // One-cycle flag for a preset that was refused
    always_ff @(posedge clk or negedge _CR) begin
        if (!_CR) begin
            load_err_r <= 1'b0;
        end else begin
            load_err_r <= bus.PE & ~pre_ok_s;
        end
    end

    // Carry/borrow is combinational so the next stage steps on the same edge;
    // a corrupted value matches neither terminal, so it never carries
    assign bus.cout     = _CR & bus.cin & ~bus.PE & (bus.dir ? at_min_s : at_max_s);
    assign bus.show     = show_s;
    assign bus.load_err = load_err_r;

endmodule
